// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_R2   = 2'b11;
    localparam logic [1:0] SRC_R2R3 = 2'b10;

    localparam logic [3:0] REG_ZERO = 4'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble insertion, memory-wait freeze and timeout halt for the vector ASIP pipeline.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rs2_d,
    input  logic [3:0]       rs3_d,
    input  logic [1:0]       src_sel_d,
    input  logic [3:0]       dest_e,
    input  logic             load_e,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             stall_em,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [1:0]        bub_q, bub_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              hazard, mstall;

    assign hazard = load_e && (dest_e != REG_ZERO) &&
                    ((src_sel_d[1] && (rs2_d == dest_e)) ||
                     ((src_sel_d == SRC_R2R3) && (rs3_d == dest_e)));
    assign mstall = mem_req_m && !mem_ready;

    always_comb begin
        state_d  = state_q;
        bub_d    = bub_q;
        wait_d   = wait_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_e  = 1'b0;
        stall_em = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mstall) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_em = 1'b1;
                end else if (hazard) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = BUBBLE;
                        bub_d   = 2'(LOAD_BUBBLES - 1);
                    end
                end
            end
            // EX holds a bubble here, so a fresh hazard cannot exist yet.
            BUBBLE: begin
                if (mstall) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_em = 1'b1;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    bub_d   = bub_q - 2'd1;
                    if (bub_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_em = 1'b1;
                halted   = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (state_q != HALT) begin
            if (mstall) begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = HALT;
                end
            end else begin
                wait_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            bub_q   <= 2'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall_f),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two configurations share stimulus, checked against a bubble/wait model.
module tb_hazard_stall_unit;

    localparam int unsigned CW_A = 16;
    localparam int unsigned CW_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] rs2_d = '0, rs3_d = '0, dest_e = '0;
    logic [1:0] src_sel_d = '0;
    logic       load_e = 1'b0, mem_req_m = 1'b0, mem_ready = 1'b0, cnt_clr = 1'b0;

    logic            stall_f_a, stall_d_a, flush_e_a, stall_em_a, halted_a;
    logic            stall_f_b, stall_d_b, flush_e_b, stall_em_b, halted_b;
    logic [CW_A-1:0] stall_cycles_a;
    logic [CW_B-1:0] stall_cycles_b;

    // Output vectors ordered {stall_f, stall_d, flush_e, stall_em, halted}
    wire [4:0] obs_a = {stall_f_a, stall_d_a, flush_e_a, stall_em_a, halted_a};
    wire [4:0] obs_b = {stall_f_b, stall_d_b, flush_e_b, stall_em_b, halted_b};

    hazard_stall_unit #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .rs2_d(rs2_d), .rs3_d(rs3_d), .src_sel_d(src_sel_d),
        .dest_e(dest_e), .load_e(load_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .stall_f(stall_f_a), .stall_d(stall_d_a), .flush_e(flush_e_a),
        .stall_em(stall_em_a), .halted(halted_a), .stall_cycles(stall_cycles_a)
    );

    hazard_stall_unit #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .rs2_d(rs2_d), .rs3_d(rs3_d), .src_sel_d(src_sel_d),
        .dest_e(dest_e), .load_e(load_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .stall_f(stall_f_b), .stall_d(stall_d_b), .flush_e(flush_e_b),
        .stall_em(stall_em_b), .halted(halted_b), .stall_cycles(stall_cycles_b)
    );

    int checks = 0;
    int failures = 0;

    // Model: bubbles still owed, consecutive wait cycles, halt flag, stall count
    int m_left[2] = '{0, 0};
    int m_wait[2] = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    bit m_halt[2] = '{0, 0};
    int lb[2]     = '{1, 3};
    int to[2]     = '{255, 4};
    int cmax[2]   = '{65535, 15};

    function automatic bit model_hz();
        bit uses_r2 = (src_sel_d == 2'b11) || (src_sel_d == 2'b10);
        bit uses_r3 = (src_sel_d == 2'b10);
        return load_e && (dest_e != 0) &&
               ((uses_r2 && rs2_d == dest_e) || (uses_r3 && rs3_d == dest_e));
    endfunction

    function automatic logic [4:0] model_out(int i);
        bit ms = mem_req_m && !mem_ready;
        if (m_halt[i]) return 5'b11011;
        if (ms) return 5'b11010;
        if (m_left[i] > 0 || model_hz()) return 5'b11100;
        return 5'b00000;
    endfunction

    task automatic step();
        logic [4:0] o;
        bit ms;
        @(posedge clk);
        ms = mem_req_m && !mem_ready;
        for (int i = 0; i < 2; i++) begin
            o = model_out(i);
            if (rst) begin
                m_left[i] = 0; m_wait[i] = 0; m_halt[i] = 0; m_cnt[i] = 0;
            end else begin
                if (cnt_clr) m_cnt[i] = 0;
                else if (o[4] && m_cnt[i] < cmax[i]) m_cnt[i]++;
                if (!m_halt[i]) begin
                    if (ms) begin
                        if (m_wait[i] == to[i] - 1) m_halt[i] = 1;
                        m_wait[i]++;
                    end else begin
                        m_wait[i] = 0;
                        if (m_left[i] > 0) m_left[i]--;
                        else if (model_hz()) m_left[i] = lb[i] - 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; rs2_d = 0; rs3_d = 0; dest_e = 0; src_sel_d = 0;
        load_e = 0; mem_req_m = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got a=%b b=%b want 00000", obs_a, obs_b);
        end
        checks++;
        if (stall_cycles_a !== '0 || stall_cycles_b !== '0) begin
            failures++;
            $display("FAIL reset_count got a=%0d b=%0d want 0", stall_cycles_a, stall_cycles_b);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_e = 1; dest_e = 5; rs2_d = 5; src_sel_d = 2'b11;
        #1;
        checks++;
        if (obs_a !== 5'b11100 || obs_b !== 5'b11100) begin
            failures++;
            $display("FAIL load_use_rs2 got a=%b b=%b want 11100", obs_a, obs_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (obs_a !== 5'b00000 || stall_cycles_a !== 16'd1) begin
            failures++;
            $display("FAIL load_use_one_bubble got a=%b cnt=%0d want 00000 cnt=1",
                     obs_a, stall_cycles_a);
        end
        checks++;
        if (obs_b !== model_out(1)) begin
            failures++;
            $display("FAIL load_use_b_bubble got %b want %b", obs_b, model_out(1));
        end
        repeat (3) step();
    endtask

    task automatic test_no_false();
        logic [3:0] dst[3] = '{4'd0, 4'd5, 4'd5};
        logic [3:0] r2[3]  = '{4'd0, 4'd3, 4'd3};
        logic [3:0] r3[3]  = '{4'd0, 4'd5, 4'd5};
        logic [1:0] sel[3] = '{2'b11, 2'b11, 2'b10};
        logic [4:0] want[3] = '{5'b00000, 5'b00000, 5'b11100};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            load_e = 1; dest_e = dst[k]; rs2_d = r2[k]; rs3_d = r3[k]; src_sel_d = sel[k];
            #1;
            checks++;
            if (obs_a !== want[k] || obs_b !== want[k]) begin
                failures++;
                $display("FAIL false_hazard_%0d got a=%b b=%b want %b", k, obs_a, obs_b, want[k]);
            end
            step();
            idle();
            repeat (3) step();
        end
    endtask

    task automatic test_bubbles_mstall();
        logic [4:0] seq[5] = '{5'b11100, 5'b11100, 5'b11010, 5'b11010, 5'b11100};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                load_e = 1; dest_e = 7; rs2_d = 7; src_sel_d = 2'b11;
            end
            if (c == 2 || c == 3) begin
                mem_req_m = 1; mem_ready = 0;
            end
            #1;
            checks++;
            if (obs_b !== seq[c] || obs_a !== model_out(0)) begin
                failures++;
                $display("FAIL bubble_mstall_c%0d got b=%b a=%b want b=%b a=%b",
                         c, obs_b, obs_a, seq[c], model_out(0));
            end
            step();
        end
        idle();
        #1;
        checks++;
        if (obs_b !== 5'b0 || stall_cycles_b !== 4'd5) begin
            failures++;
            $display("FAIL bubble_mstall_total got b=%b cnt=%0d want 00000 cnt=5",
                     obs_b, stall_cycles_b);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            mem_req_m = 1; mem_ready = (c == 3);
            #1;
            checks++;
            if (stall_em_a !== (c < 3) || halted_a !== 1'b0 || obs_b !== model_out(1)) begin
                failures++;
                $display("FAIL mem_wait_c%0d got em=%b halt=%b b=%b want em=%b halt=0 b=%b",
                         c, stall_em_a, halted_a, obs_b, c < 3, model_out(1));
            end
            step();
        end
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req_m = 1; mem_ready = 0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++;
            if (halted_b !== (c >= 5) || obs_b !== model_out(1)) begin
                failures++;
                $display("FAIL timeout_c%0d got halt=%b b=%b want halt=%b b=%b",
                         c, halted_b, obs_b, c >= 5, model_out(1));
            end
            step();
        end
        mem_ready = 1;
        #1;
        checks++;
        if (obs_b !== 5'b11011 || halted_a !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky got b=%b halt_a=%b want 11011 0", obs_b, halted_a);
        end
        step();
        rst = 1;
        #1;
        checks++;
        if (halted_b !== 1'b1) begin
            failures++;
            $display("FAIL timeout_rst_same_cycle got %b want 1", halted_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (obs_b !== 5'b0 || stall_cycles_b !== 4'd0) begin
            failures++;
            $display("FAIL timeout_after_rst got b=%b cnt=%0d want 00000 0", obs_b, stall_cycles_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            load_e    = $urandom_range(0, 1);
            dest_e    = 4'($urandom_range(0, 3));
            rs2_d     = 4'($urandom_range(0, 3));
            rs3_d     = 4'($urandom_range(0, 3));
            src_sel_d = 2'($urandom_range(0, 3));
            mem_req_m = ($urandom_range(0, 2) == 0);
            mem_ready = $urandom_range(0, 1);
            #1;
            checks++;
            if (obs_a !== model_out(0) || obs_b !== model_out(1) ||
                stall_cycles_a !== CW_A'(m_cnt[0]) || stall_cycles_b !== CW_B'(m_cnt[1])) begin
                failures++;
                $display("FAIL random_%0d got a=%b b=%b ca=%0d cb=%0d want a=%b b=%b ca=%0d cb=%0d",
                         n, obs_a, obs_b, stall_cycles_a, stall_cycles_b,
                         model_out(0), model_out(1), m_cnt[0], m_cnt[1]);
            end
            step();
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req_m = 1; mem_ready = 0;
        repeat (65536 + 3) step();
        #1;
        checks++;
        if (stall_cycles_a !== 16'hFFFF || stall_cycles_b !== 4'hF) begin
            failures++;
            $display("FAIL saturate got a=%h b=%h want ffff f", stall_cycles_a, stall_cycles_b);
        end
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        #1;
        checks++;
        if (stall_cycles_a !== 16'd0 || stall_cycles_b !== 4'd0 || obs_a !== 5'b11011) begin
            failures++;
            $display("FAIL clear_over_inc got a=%0d b=%0d obs_a=%b want 0 0 11011",
                     stall_cycles_a, stall_cycles_b, obs_a);
        end
        step();
        checks++;
        if (stall_cycles_a !== CW_A'(m_cnt[0]) || stall_cycles_b !== CW_B'(m_cnt[1])) begin
            failures++;
            $display("FAIL count_after_clear got a=%0d b=%0d want %0d %0d",
                     stall_cycles_a, stall_cycles_b, m_cnt[0], m_cnt[1]);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false();
        test_bubbles_mstall();
        test_mem_wait();
        test_timeout();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard and stall controller for the vector ASIP. It complements the forwarding path, which bypasses EX/WB results into decode operands, by handling the cases forwarding cannot cover. It detects load-use RAW hazards between the decode-stage operands and a load in EX, and inserts a configurable number of bubbles. It also freezes the back end while vector memory is not ready, and halts the core on a memory timeout. A saturating stall-cycle counter is provided for profiling.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..3.
- MEM_TIMEOUT, 255: consecutive memory-stall cycles tolerated before halting; legal range ≥2.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs2_d  in  4  decode-stage source register 2.
- rs3_d  in  4  decode-stage source register 3.
- src_sel_d  in  2  operand-use code: 2'b0x = no register sources; 2'b11 = rs2 only; 2'b10 = rs2 and rs3.
- dest_e  in  4  destination register of the instruction in EX.
- load_e  in  1  instruction in EX is a memory load.
- mem_req_m  in  1  MEM stage has an active memory access.
- mem_ready  in  1  memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of stall_cycles.
- stall_f  out  1  hold the PC/fetch register.
- stall_d  out  1  hold the IF/ID register.
- flush_e  out  1  load a bubble into ID/EX.
- stall_em  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- halted  out  1  core is halted by a memory timeout (sticky).
- stall_cycles  out  CNT_W  number of cycles with stall_f=1; saturating.

## Operation
- Definitions:
  - hazard = load_e & (dest_e≠0) & ((src_sel_d[1] & rs2_d==dest_e) | (src_sel_d==2'b10 & rs3_d==dest_e)).
  - Register 0 never hazards.
  - mstall = mem_req_m & ~mem_ready.
- FSM states are RUN, BUBBLE and HALT.
- Outputs are Mealy, combinational from the current state and the inputs.
- Memory stall has priority in RUN and BUBBLE. When mstall=1:
  - stall_f, stall_d and stall_em are 1; flush_e is 0.
  - There is no state change other than the timeout check.
  - The bubble counter is frozen.
- RUN with no mstall:
  - hazard=1: stall_f=stall_d=flush_e=1 and stall_em=0.
  - If LOAD_BUBBLES>1, go to BUBBLE with bub_cnt=LOAD_BUBBLES-1; otherwise stay in RUN.
  - hazard=0: all stall outputs are 0.
- BUBBLE with no mstall:
  - stall_f=stall_d=flush_e=1.
  - bub_cnt decrements; when bub_cnt==1, the next state is RUN.
  - hazard is ignored in BUBBLE, because EX holds a bubble.
- Timeout:
  - wait_cnt clears on any cycle with mstall=0 and increments on each mstall cycle.
  - If mstall=1 and wait_cnt==MEM_TIMEOUT-1, the next state is HALT.
- HALT:
  - stall_f=stall_d=stall_em=1, flush_e=0, halted=1.
  - HALT is left only by rst.
- stall_cycles:
  - Increments on every cycle with stall_f=1, including HALT, and saturates at all ones.
  - cnt_clr=1 loads 0, overriding the increment in that cycle.
- Reset values:
  - state=RUN, bub_cnt=0, wait_cnt=0, stall_cycles=0, halted=0.
  - With idle inputs, all stall and flush outputs are 0.

## Timing
- Hazard response has zero latency: stall and flush assert in the same cycle the hazard is visible.
- A dependent instruction leaves decode after LOAD_BUBBLES cycles, plus any intervening mstall cycles.
- mem_ready=1 in the same cycle as mem_req_m causes no stall.
- A stall released by mem_ready lets the pipeline advance in that cycle.
- rst in the middle of BUBBLE or HALT returns to RUN on the next edge; outputs follow the reset values from that edge onward.
- Simultaneous hazard and mstall in RUN: the cycle is a memory stall with no flush; the hazard is re-evaluated next cycle.

## Structure
- Package hazard_pkg holds:
  - the state enum {RUN, BUBBLE, HALT};
  - SRC_NONE, SRC_R2 (2'b11) and SRC_R2R3 (2'b10);
  - REG_ZERO=4'h0.
- Sub-module sat_counter #(W) holds the saturating, clearable counter. It is instantiated for stall_cycles.
- wait_cnt width is $clog2(MEM_TIMEOUT+1).

## Test plan
- Load-use on rs2: load_e=1, dest_e=5; rs2_d=5, src_sel_d=11; LOAD_BUBBLES=1 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; stall_cycles=1.
- No false hazards:
  - dest_e=0 with rs2_d=0 -> no stall.
  - rs3_d=5 with src_sel_d=11 (rs3 unused) -> no stall.
  - src_sel_d=10 with rs3_d=5 -> stall.
- LOAD_BUBBLES=3 with a hazard -> 3 consecutive flush_e cycles. Injecting mstall on bubble 2 for 2 cycles yields 5 total stall_f cycles with flush_e=0 during the mstall cycles.
- Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles, then 1 -> stall_em=1 for 3 cycles and 0 in the ready cycle; no halt at MEM_TIMEOUT=255.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 -> halted=1 from cycle 5. It stays 1 after mem_ready=1 and clears only one edge after rst=1.
- Counter: force 2^CNT_W+3 stall cycles -> stall_cycles holds at all ones. cnt_clr together with a stall cycle -> 0.
